// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver, LSB first, with bit-centre sampling,
//               framing-error detection and break (held-low line) handling.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CLKS_PER_BIT : clk cycles per serial bit (8..65535), default 434
// Ports
//   clk          : system clock, rising edge
//   rst          : synchronous active-high reset
//   i_RX_Serial  : asynchronous serial input, idle high
//   o_RX_DV      : one-cycle pulse, o_RX_Byte holds a newly received byte
//   o_RX_Byte    : last correctly framed byte, held until the next one
//   o_RX_FE      : one-cycle pulse, stop bit was sampled low
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_RX_Serial,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_FE
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    // Start bit is checked at its centre; every later sample is one full bit
    // period after the previous, which keeps all samples near bit centres.
    localparam logic [CW-1:0] c_MID_CNT  = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] c_LAST_CNT = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_CLEANUP   = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    logic          rx_meta_q;
    logic          rx_s_q;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    byte_q, byte_d;
    logic          dv_q, dv_d;
    logic          fe_q, fe_d;

    // Two-flop synchronizer; resets to the idle (high) line level so a reset
    // never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= i_RX_Serial;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            byte_q  <= 8'h00;
            dv_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            dv_q    <= dv_d;
            fe_q    <= fe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        dv_d    = 1'b0;
        fe_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = 3'd0;
                if (!rx_s_q) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                if (cnt_q == c_MID_CNT) begin
                    cnt_d = '0;
                    idx_d = 3'd0;
                    // Line back high at mid start bit: treat as a glitch.
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_DATA: begin
                if (cnt_q == c_LAST_CNT) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s_q;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_STOP: begin
                if (cnt_q == c_LAST_CNT) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        byte_d  = shift_q;
                        dv_d    = 1'b1;
                        state_d = S_CLEANUP;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = S_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_CLEANUP: begin
                state_d = S_IDLE;
            end

            // After a framing error the line may still be low (break); wait
            // for it to return high so the low level is not taken as a start.
            S_WAIT_IDLE: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_RX_DV   = dv_q;
    assign o_RX_FE   = fe_q;
    assign o_RX_Byte = byte_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Directed self-checking bench for uart_rx (434 clk/bit at
//               20 ns, plus a second instance at 8 clk/bit on a 10 ns clock).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int CPB  = 434;
    localparam int CPB2 = 8;
    localparam int LAT  = 9 * CPB + (CPB - 1) / 2 + 4;
    localparam int LAT2 = 9 * CPB2 + (CPB2 - 1) / 2 + 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       dv;
    logic       fe;
    logic [7:0] byte_o;

    logic       clk2 = 1'b0;
    logic       rst2 = 1'b1;
    logic       rx2  = 1'b1;
    logic       dv2;
    logic       fe2;
    logic [7:0] byte2;

    always #10 clk  = ~clk;
    always #5  clk2 = ~clk2;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_RX_Serial (rx),
        .o_RX_DV     (dv),
        .o_RX_Byte   (byte_o),
        .o_RX_FE     (fe)
    );

    uart_rx #(.CLKS_PER_BIT(CPB2)) dut2 (
        .clk         (clk2),
        .rst         (rst2),
        .i_RX_Serial (rx2),
        .o_RX_DV     (dv2),
        .o_RX_Byte   (byte2),
        .o_RX_FE     (fe2)
    );

    int total = 0;
    int bad   = 0;

    // Monitor for the main instance
    int         cyc = 0;
    logic       rst_at_edge = 1'b1;
    int         dv_cnt = 0, fe_cnt = 0, both_cnt = 0, wide_viol = 0, hold_viol = 0;
    int         last_dv_cyc = 0;
    logic       dv_prev = 1'b0, fe_prev = 1'b0;
    logic [7:0] byte_prev = 8'h00;
    logic [7:0] rx_q[$];

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst;
    end

    always @(negedge clk) begin
        if (dv) begin
            dv_cnt      <= dv_cnt + 1;
            last_dv_cyc <= cyc;
            rx_q.push_back(byte_o);
        end
        if (fe)               fe_cnt    <= fe_cnt + 1;
        if (dv && fe)         both_cnt  <= both_cnt + 1;
        if (dv && dv_prev)    wide_viol <= wide_viol + 1;
        if (fe && fe_prev)    wide_viol <= wide_viol + 1;
        if ((byte_o !== byte_prev) && !dv && !rst_at_edge) hold_viol <= hold_viol + 1;
        dv_prev   <= dv;
        fe_prev   <= fe;
        byte_prev <= byte_o;
    end

    // Monitor for the 8 clk/bit instance
    int cyc2 = 0, dv2_cnt = 0, fe2_cnt = 0, last_dv2_cyc = 0;
    always @(posedge clk2) cyc2 <= cyc2 + 1;
    always @(negedge clk2) begin
        if (dv2) begin
            dv2_cnt      <= dv2_cnt + 1;
            last_dv2_cyc <= cyc2;
        end
        if (fe2) fe2_cnt <= fe2_cnt + 1;
    end

    int last_start = 0;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one full 8N1 frame starting at a falling clk edge.
    task automatic send(input logic [7:0] b, input logic stop_v);
        rx = 1'b0;
        last_start = cyc;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop_v;
        tick(CPB);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(5);
        total++; if (byte_o !== 8'h00) begin bad++; $display("FAIL reset_byte: got %h want 00", byte_o); end
        total++; if (dv !== 1'b0)      begin bad++; $display("FAIL reset_dv: got %b want 0", dv); end
        total++; if (fe !== 1'b0)      begin bad++; $display("FAIL reset_fe: got %b want 0", fe); end
        rst = 1'b0;
        tick(20);
        total++; if (byte_o !== 8'h00 || dv_cnt != 0) begin
            bad++; $display("FAIL idle_after_reset: byte %h dv_cnt %0d want 00 / 0", byte_o, dv_cnt);
        end
    endtask

    task automatic test_single;
        int d0 = dv_cnt;
        int f0 = fe_cnt;
        int lat;
        send(8'h37, 1'b1);
        lat = last_dv_cyc - last_start;
        total++; if (dv_cnt - d0 != 1) begin bad++; $display("FAIL single_dv_count: got %0d want 1", dv_cnt - d0); end
        total++; if (rx_q.size() == 0 || rx_q[$] !== 8'h37) begin
            bad++; $display("FAIL single_dv_byte: got %h want 37", (rx_q.size() == 0) ? 8'hxx : rx_q[$]);
        end
        total++; if (lat < LAT - 2 || lat > LAT + 2) begin bad++; $display("FAIL single_latency: got %0d want %0d+-2", lat, LAT); end
        tick(5);
        total++; if (byte_o !== 8'h37) begin bad++; $display("FAIL single_hold: got %h want 37", byte_o); end
        total++; if (fe_cnt != f0)     begin bad++; $display("FAIL single_fe: got %0d pulses want 0", fe_cnt - f0); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp [3] = '{8'h00, 8'hFF, 8'hA5};
        int f0 = fe_cnt;
        rx_q.delete();
        for (int i = 0; i < 3; i++) send(exp[i], 1'b1);
        tick(CPB);
        total++; if (rx_q.size() != 3) begin bad++; $display("FAIL b2b_count: got %0d want 3", rx_q.size()); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (i >= rx_q.size() || rx_q[i] !== exp[i]) begin
                bad++; $display("FAIL b2b_byte%0d: got %h want %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp[i]);
            end
        end
        total++; if (fe_cnt != f0) begin bad++; $display("FAIL b2b_fe: got %0d pulses want 0", fe_cnt - f0); end
    endtask

    task automatic test_break;
        int d0 = dv_cnt;
        int f0 = fe_cnt;
        rx = 1'b0;
        tick(100);
        rx = 1'b1;
        tick(2 * CPB);
        total++; if (dv_cnt != d0 || fe_cnt != f0) begin
            bad++; $display("FAIL short_low: dv %0d fe %0d pulses want 0/0", dv_cnt - d0, fe_cnt - f0);
        end
        send(8'h5A, 1'b1);
        tick(CPB);
        total++; if (dv_cnt != d0 + 1 || byte_o !== 8'h5A) begin
            bad++; $display("FAIL after_short_low: dv %0d byte %h want 1 / 5a", dv_cnt - d0, byte_o);
        end
    endtask

    task automatic test_framing;
        int d0 = dv_cnt;
        int f0 = fe_cnt;
        send(8'h3C, 1'b0);
        tick(2 * CPB);
        rx = 1'b1;
        tick(2 * CPB);
        total++; if (fe_cnt != f0 + 1) begin bad++; $display("FAIL fe_count: got %0d want 1", fe_cnt - f0); end
        total++; if (dv_cnt != d0 || byte_o !== 8'h5A) begin
            bad++; $display("FAIL fe_no_dv: dv %0d byte %h want 0 / 5a", dv_cnt - d0, byte_o);
        end
        send(8'h81, 1'b1);
        tick(CPB);
        total++; if (dv_cnt != d0 + 1 || byte_o !== 8'h81) begin
            bad++; $display("FAIL after_fe: dv %0d byte %h want 1 / 81", dv_cnt - d0, byte_o);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] b = 8'h37;
        int d0 = dv_cnt;
        int f0 = fe_cnt;
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (i == 4) begin
                tick(CPB / 2);
                rst = 1'b1;
                tick(3);
                rst = 1'b0;
                tick(CPB - CPB / 2 - 3);
            end else begin
                tick(CPB);
            end
        end
        rx = 1'b1;
        tick(CPB);
        total++; if (dv_cnt != d0 || fe_cnt != f0) begin
            bad++; $display("FAIL rst_mid_pulses: dv %0d fe %0d want 0/0", dv_cnt - d0, fe_cnt - f0);
        end
        total++; if (byte_o !== 8'h00) begin bad++; $display("FAIL rst_mid_byte: got %h want 00", byte_o); end
        // The low data bits after reset release look like a start bit; let
        // that partial frame run out on an idle line before the next frame.
        tick(12 * CPB);
        d0 = dv_cnt;
        send(8'hC3, 1'b1);
        tick(CPB);
        total++; if (dv_cnt != d0 + 1 || byte_o !== 8'hC3) begin
            bad++; $display("FAIL after_rst_mid: dv %0d byte %h want 1 / c3", dv_cnt - d0, byte_o);
        end
    endtask

    task automatic test_small_clks;
        logic [7:0] b = 8'h37;
        int start;
        int lat;
        rst2 = 1'b1;
        repeat (4) @(negedge clk2);
        rst2 = 1'b0;
        repeat (10) @(negedge clk2);
        rx2 = 1'b0;
        start = cyc2;
        repeat (CPB2) @(negedge clk2);
        for (int i = 0; i < 8; i++) begin
            rx2 = b[i];
            repeat (CPB2) @(negedge clk2);
        end
        rx2 = 1'b1;
        repeat (CPB2) @(negedge clk2);
        repeat (5) @(negedge clk2);
        lat = last_dv2_cyc - start;
        total++; if (dv2_cnt != 1)     begin bad++; $display("FAIL small_dv_count: got %0d want 1", dv2_cnt); end
        total++; if (byte2 !== 8'h37)  begin bad++; $display("FAIL small_byte: got %h want 37", byte2); end
        total++; if (fe2_cnt != 0)     begin bad++; $display("FAIL small_fe: got %0d want 0", fe2_cnt); end
        total++; if (lat < LAT2 - 2 || lat > LAT2 + 2) begin bad++; $display("FAIL small_latency: got %0d want %0d+-2", lat, LAT2); end
    endtask

    task automatic test_invariants;
        total++; if (both_cnt != 0)  begin bad++; $display("FAIL dv_fe_overlap: got %0d cycles want 0", both_cnt); end
        total++; if (wide_viol != 0) begin bad++; $display("FAIL pulse_width: got %0d wide pulses want 0", wide_viol); end
        total++; if (hold_viol != 0) begin bad++; $display("FAIL byte_hold: got %0d changes without dv want 0", hold_viol); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_break();
        test_framing();
        test_reset_mid();
        test_small_clks();
        test_invariants();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, meaning clock cycles per serial bit (50 MHz clock / 115200 baud); legal range 8..65535.
REQ-002 clk  input  1  the single system clock; all logic is clocked on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 i_RX_Serial  input  1  asynchronous serial line; idle high; 8N1 framing, LSB first.
REQ-005 o_RX_DV  output  1  one-cycle pulse that marks a valid received byte.
REQ-006 o_RX_Byte  output  8  last correctly framed byte; held until the next valid byte.
REQ-007 o_RX_FE  output  1  one-cycle pulse that marks a framing error (stop bit sampled low).

Function
REQ-008 i_RX_Serial shall pass through a 2-flop synchronizer (rx_s) before any use; the synchronizer flops reset to 1.
REQ-009 The state machine shall have the states IDLE, START, DATA, STOP, CLEANUP and WAIT_IDLE, with a clock counter of width $clog2(CLKS_PER_BIT) and a 3-bit bit index.
REQ-010 IDLE: when rx_s=0, the FSM shall go to START with the counter cleared; otherwise it stays in IDLE.
REQ-011 START: at count (CLKS_PER_BIT-1)/2 (the mid start bit), if rx_s=0 the FSM shall go to DATA with counter=0 and index=0; if rx_s=1 (glitch) it shall return to IDLE with no output activity.
REQ-012 DATA: at count CLKS_PER_BIT-1, rx_s shall be stored into shift-register bit [index] and the counter cleared; after index 7 the FSM goes to STOP, otherwise the index increments.
REQ-013 STOP: at count CLKS_PER_BIT-1 (the mid stop bit), if rx_s=1 then o_RX_Byte shall load the shift register, o_RX_DV shall pulse for exactly 1 clk, and the FSM goes to CLEANUP.
REQ-014 STOP with rx_s=0 shall pulse o_RX_FE for 1 clk, leave o_RX_Byte unchanged, keep o_RX_DV low, and go to WAIT_IDLE.
REQ-015 WAIT_IDLE shall remain until rx_s=1, then go to IDLE, so a held-low line (break) is not re-detected as a start bit.
REQ-016 CLEANUP shall last 1 clk, then go to IDLE; a new start bit arriving right after the stop-bit midpoint shall be received correctly (back-to-back frames).
REQ-017 o_RX_DV and o_RX_FE shall never be high in the same cycle, and each is low outside its single pulse cycle.
REQ-018 Latency: o_RX_DV shall rise 9*CLKS_PER_BIT + (CLKS_PER_BIT-1)/2 + 4 clks (±2) after the falling start edge on i_RX_Serial, i.e. before the stop bit ends.
REQ-019 o_RX_Byte shall not change except on an o_RX_DV cycle or on reset.
REQ-020 The sample point is the bit centre, giving a tolerance of at least ±4% baud mismatch over a frame.

Reset
REQ-021 While rst=1 at a clk edge: FSM=IDLE, counter=0, index=0, shift register=0, o_RX_Byte=8'h00, o_RX_DV=0, o_RX_FE=0, synchronizer flops=1.
REQ-022 Reset asserted mid-frame shall abort the frame with no DV or FE pulse; after rst deasserts the block waits in IDLE for the next falling edge.
REQ-023 Until the first valid byte after reset, o_RX_Byte shall read 8'h00.

Verification
REQ-024 Send 0x37 at 434 clk/bit, 20 ns clk -> exactly one o_RX_DV pulse during the stop bit; o_RX_Byte=0x37 and still 0x37 five clks after the stop bit ends; o_RX_FE stays 0.
REQ-025 Send 0x00, 0xFF, 0xA5 back-to-back with no idle gap -> three DV pulses with bytes 0x00, 0xFF, 0xA5 in order; no FE.
REQ-026 Drive the line low for 100 clks, then high -> no DV, no FE; FSM back in IDLE; a following 0x5A is then received correctly.
REQ-027 Send a frame 0x3C with its stop bit low, line held low 2 bit periods, then high -> one FE pulse, no DV, o_RX_Byte keeps its previous value; a subsequent 0x81 yields DV with 0x81.
REQ-028 Assert rst for 3 clks during data bit 4 of 0x37 -> no DV or FE pulse, o_RX_Byte=0x00; a following 0xC3 is received correctly.
REQ-029 Re-run REQ-024 with CLKS_PER_BIT=8 and a 10 ns clk -> o_RX_Byte=0x37 with a single DV pulse.
